alu_exec_unit: RTL and testbench

- Parametrised execution unit that replaces the fixed 3-register, 8-bit processor datapath.
- Combines an N-entry register file with a handshaked instruction port.
- Logic, shift, compare and load ops complete in one cycle; MUL, MULH, DIV and MOD run iteratively over DATA_W cycles.
- Results write back to the register file and are reported with a registered valid pulse and flags.

---
 rtl/alu_exec_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: register-file execution unit with a valid/ready instruction port.
// Logic, shift, compare and load ops write back at the accept edge. MUL, MULH, DIV
// and MOD take one shift-add or restoring-divide step per cycle, DATA_W steps in all.
//
//   state  | meaning
//   S_IDLE | ready for an instruction; single-cycle ops execute here
//   S_ITER | iterative multiply/divide in flight; instr_ready low
module alu_exec_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_sign,
  output logic              flag_parity,
  output logic              flag_overflow,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_GT   = 5'd8;
  localparam logic [4:0] OP_LT   = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_LDI  = 5'd15;
  localparam logic [4:0] OP_MULH = 5'd16;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t            r_state;
  state_t            w_state_n;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_opnd;
  logic [4:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic              r_divz;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_accept;
  logic              w_iter_done;
  logic              w_is_iter;

  logic              w_first;
  logic              w_s_div;
  logic [DATA_W-1:0] w_s_hi;
  logic [DATA_W-1:0] w_s_lo;
  logic [DATA_W-1:0] w_s_opnd;
  logic [DATA_W:0]   w_mul_sum;
  logic [DATA_W-1:0] w_mul_hi_n;
  logic [DATA_W-1:0] w_mul_lo_n;
  logic [DATA_W:0]   w_div_sh;
  logic              w_div_ge;
  logic [DATA_W-1:0] w_div_diff;
  logic [DATA_W-1:0] w_div_rem_n;
  logic [DATA_W-1:0] w_div_quo_n;
  logic [DATA_W-1:0] w_step_hi;
  logic [DATA_W-1:0] w_step_lo;

  logic [DATA_W:0]   w_add_full;
  logic [DATA_W-1:0] w_sub;

  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_wr_carry;
  logic              w_wr_ovf;

  assign w_a      = r_regs[instr_rd];
  assign w_b      = r_regs[instr_rs];
  assign dbg_data = r_regs[dbg_addr];

  assign w_is_iter = (instr_op == OP_MUL) || (instr_op == OP_MULH) ||
                     (instr_op == OP_DIV) || (instr_op == OP_MOD);

  // The accept edge performs the first iteration step straight from the register
  // file, so the step inputs come from A/B in IDLE and from the working regs in ITER.
  assign w_first  = (r_state == S_IDLE);
  assign w_s_div  = w_first ? ((instr_op == OP_DIV) || (instr_op == OP_MOD))
                            : ((r_op == OP_DIV) || (r_op == OP_MOD));
  assign w_s_hi   = w_first ? '0 : r_hi;
  assign w_s_lo   = w_first ? (w_s_div ? w_a : w_b) : r_lo;
  assign w_s_opnd = w_first ? (w_s_div ? w_b : w_a) : r_opnd;

  // Shift-add multiply: hi accumulates, lo holds the multiplier and fills with product bits.
  assign w_mul_sum  = {1'b0, w_s_hi} + (w_s_lo[0] ? {1'b0, w_s_opnd} : '0);
  assign w_mul_hi_n = w_mul_sum[DATA_W:1];
  assign w_mul_lo_n = {w_mul_sum[0], w_s_lo[DATA_W-1:1]};

  // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // A zero divisor always "fits", which yields an all-ones quotient and remainder == A.
  assign w_div_sh    = {w_s_hi, w_s_lo[MSB]};
  assign w_div_ge    = (w_div_sh >= {1'b0, w_s_opnd});
  assign w_div_diff  = w_div_sh[DATA_W-1:0] - w_s_opnd;
  assign w_div_rem_n = w_div_ge ? w_div_diff : w_div_sh[DATA_W-1:0];
  assign w_div_quo_n = {w_s_lo[DATA_W-2:0], w_div_ge};

  assign w_step_hi = w_s_div ? w_div_rem_n : w_mul_hi_n;
  assign w_step_lo = w_s_div ? w_div_quo_n : w_mul_lo_n;

  assign w_add_full = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub      = w_a - w_b;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Next state, handshake, and completion of the iterative op.
  // The counter is one more than the steps still to run, so the last step is at 2.
  always_comb begin
    w_state_n   = r_state;
    instr_ready = 1'b0;
    w_accept    = 1'b0;
    w_iter_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        w_accept    = instr_valid;
        if (instr_valid && w_is_iter) w_state_n = S_ITER;
      end
      S_ITER: begin
        if (r_cnt == CNT_W'(2)) begin
          w_iter_done = 1'b1;
          w_state_n   = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Iterative datapath: capture operands at accept, then one step per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opnd <= '0;
      r_op   <= '0;
      r_rd   <= '0;
      r_divz <= 1'b0;
    end else if (w_accept && w_is_iter) begin
      r_cnt  <= CNT_W'(DATA_W);
      r_hi   <= w_step_hi;
      r_lo   <= w_step_lo;
      r_opnd <= w_s_opnd;
      r_op   <= instr_op;
      r_rd   <= instr_rd;
      r_divz <= (w_b == '0);
    end else if (r_state == S_ITER) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_hi   <= w_step_hi;
      r_lo   <= w_step_lo;
    end
  end

  // Writeback selection: finishing iterative op, or a single-cycle op at accept.
  always_comb begin
    w_we       = 1'b0;
    w_wr_addr  = instr_rd;
    w_wr_data  = '0;
    w_wr_carry = 1'b0;
    w_wr_ovf   = 1'b0;
    if (w_iter_done) begin
      w_we      = 1'b1;
      w_wr_addr = r_rd;
      case (r_op)
        OP_MUL: begin
          w_wr_data = w_step_lo;
          w_wr_ovf  = (w_step_hi != '0);
        end
        OP_MULH: begin
          w_wr_data = w_step_hi;
          w_wr_ovf  = (w_step_hi != '0);
        end
        OP_DIV: begin
          w_wr_data = w_step_lo;
          w_wr_ovf  = r_divz;
        end
        default: begin
          w_wr_data = w_step_hi;
          w_wr_ovf  = r_divz;
        end
      endcase
    end else if (w_accept && !w_is_iter) begin
      w_we = 1'b1;
      case (instr_op)
        OP_ADD: begin
          w_wr_data  = w_add_full[DATA_W-1:0];
          w_wr_carry = w_add_full[DATA_W];
          w_wr_ovf   = (w_a[MSB] == w_b[MSB]) && (w_add_full[MSB] != w_a[MSB]);
        end
        OP_SUB: begin
          w_wr_data  = w_sub;
          w_wr_carry = (w_a < w_b);
          w_wr_ovf   = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
        end
        OP_AND: w_wr_data = w_a & w_b;
        OP_OR:  w_wr_data = w_a | w_b;
        OP_XOR: w_wr_data = w_a ^ w_b;
        OP_GT:  w_wr_data = {{(DATA_W-1){1'b0}}, (w_a >  w_b)};
        OP_LT:  w_wr_data = {{(DATA_W-1){1'b0}}, (w_a <  w_b)};
        OP_EQ:  w_wr_data = {{(DATA_W-1){1'b0}}, (w_a == w_b)};
        OP_NE:  w_wr_data = {{(DATA_W-1){1'b0}}, (w_a != w_b)};
        OP_MOV: w_wr_data = w_b;
        OP_SHL: begin
          w_wr_data  = {w_a[DATA_W-2:0], 1'b0};
          w_wr_carry = w_a[MSB];
        end
        OP_SHR: begin
          w_wr_data  = {1'b0, w_a[DATA_W-1:1]};
          w_wr_carry = w_a[0];
        end
        OP_LDI: w_wr_data = instr_imm;
        default: w_we = 1'b0;
      endcase
    end
  end

  // Register file write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Result, valid pulse and flags; flags hold across cycles with no write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      result        <= '0;
      flag_zero     <= 1'b0;
      flag_carry    <= 1'b0;
      flag_sign     <= 1'b0;
      flag_parity   <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      result_valid <= w_we;
      if (w_we) begin
        result        <= w_wr_data;
        flag_zero     <= (w_wr_data == '0);
        flag_carry    <= w_wr_carry;
        flag_sign     <= w_wr_data[MSB];
        flag_parity   <= ~^w_wr_data;
        flag_overflow <= w_wr_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a behavioural model pushes expected writebacks
// to a queue at issue time; a monitor pops and compares on every result_valid.
module tb_alu_exec_unit;

  localparam int W  = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  MUL = 5'd2,  DIV = 5'd3,  MOD = 5'd4;
  localparam logic [4:0] AND_ = 5'd5, OR_ = 5'd6,  XOR_ = 5'd7, GT = 5'd8,   LT = 5'd9;
  localparam logic [4:0] EQ = 5'd10,  NE = 5'd11,  MOV = 5'd12, SHL = 5'd13, SHR = 5'd14;
  localparam logic [4:0] LDI = 5'd15, MULH = 5'd16, NOP = 5'd20;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [4:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [W-1:0]  instr_imm;
  logic          result_valid;
  logic [W-1:0]  result;
  logic          flag_zero, flag_carry, flag_sign, flag_parity, flag_overflow;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;

  typedef struct packed {
    logic [W-1:0] res;
    logic z, c, s, p, v;
    logic we;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic [W-1:0] mdl [NR];
  int           n_checks = 0;
  int           n_fail   = 0;

  alu_exec_unit #(.DATA_W(W), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .result_valid(result_valid), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
    .flag_parity(flag_parity), .flag_overflow(flag_overflow),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] imm);
    exp_t        e;
    logic [W:0]  s9;
    logic [15:0] p16;
    e   = '0;
    e.we = 1'b1;
    s9  = {1'b0, a} + {1'b0, b};
    p16 = 16'(a) * 16'(b);
    case (op)
      ADD:  begin e.res = s9[W-1:0]; e.c = s9[W]; e.v = (a[7] == b[7]) && (s9[7] != a[7]); end
      SUB:  begin e.res = a - b; e.c = (a < b); e.v = (a[7] != b[7]) && (e.res[7] != a[7]); end
      MUL:  begin e.res = p16[7:0];  e.v = (p16[15:8] != 0); end
      MULH: begin e.res = p16[15:8]; e.v = (p16[15:8] != 0); end
      DIV:  begin e.res = (b == 0) ? 8'hFF : a / b; e.v = (b == 0); end
      MOD:  begin e.res = (b == 0) ? a : a % b;     e.v = (b == 0); end
      AND_: e.res = a & b;
      OR_:  e.res = a | b;
      XOR_: e.res = a ^ b;
      GT:   e.res = (a >  b) ? 8'd1 : 8'd0;
      LT:   e.res = (a <  b) ? 8'd1 : 8'd0;
      EQ:   e.res = (a == b) ? 8'd1 : 8'd0;
      NE:   e.res = (a != b) ? 8'd1 : 8'd0;
      MOV:  e.res = b;
      SHL:  begin e.res = {a[6:0], 1'b0}; e.c = a[7]; end
      SHR:  begin e.res = {1'b0, a[7:1]}; e.c = a[0]; end
      LDI:  e.res = imm;
      default: e.we = 1'b0;
    endcase
    e.z = (e.res == 0);
    e.s = e.res[7];
    e.p = ~^e.res;
    return e;
  endfunction

  // Scoreboard monitor: every result_valid must match the oldest expected writeback.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: result_valid with result=%h, expected no result", result);
      end else begin
        mon_e = q.pop_front();
        if ({result, flag_zero, flag_carry, flag_sign, flag_parity, flag_overflow} !==
            {mon_e.res, mon_e.z, mon_e.c, mon_e.s, mon_e.p, mon_e.v}) begin
          n_fail++;
          $display("FAIL sb_result: got res=%h zcspv=%b%b%b%b%b, expected res=%h zcspv=%b%b%b%b%b",
                   result, flag_zero, flag_carry, flag_sign, flag_parity, flag_overflow,
                   mon_e.res, mon_e.z, mon_e.c, mon_e.s, mon_e.p, mon_e.v);
        end
      end
    end
  end

  // Drive one instruction from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [4:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [W-1:0] imm);
    int   waited;
    exp_t e;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_imm   = imm;
    instr_valid = 1'b1;
    waited      = 0;
    while (!instr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: instr_ready=0 after %0d cycles, expected 1", waited);
      instr_valid = 1'b0;
      return;
    end
    e = model(op, mdl[rd], mdl[rs], imm);
    if (e.we) begin
      mdl[rd] = e.res;
      q.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Count cycles from the first post-accept cycle (1) until result_valid.
  task automatic wait_result(output int lat, output int low);
    lat = 1;
    low = 0;
    while (!result_valid && lat < 40) begin
      if (!instr_ready) low++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    instr_imm   = '0;
    dbg_addr    = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({instr_ready, result_valid, result, flag_zero, flag_carry, flag_sign, flag_parity,
         flag_overflow} !== {1'b1, 1'b0, 8'h00, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b res=%h, expected rdy=1 rv=0 res=00 flags=0",
               instr_ready, result_valid, result);
    end
    for (int i = 0; i < NR; i++) begin
      mdl[i]   = '0;
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if (dbg_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, expected 00", i, dbg_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    send(LDI, 0, 0, 8'd5);
    send(LDI, 1, 0, 8'd3);
    send(ADD, 0, 1, 0);
    n_checks++;
    if ({result_valid, result, flag_zero, flag_carry, flag_parity} !== {1'b1, 8'h08, 3'b000}) begin
      n_fail++;
      $display("FAIL add_basic: got rv=%b res=%h z=%b c=%b p=%b, expected rv=1 res=08 z=0 c=0 p=0",
               result_valid, result, flag_zero, flag_carry, flag_parity);
    end
    dbg_addr = 0;
    #1;
    n_checks++;
    if (dbg_data !== 8'h08) begin
      n_fail++;
      $display("FAIL add_dbg_r0: got %h, expected 08", dbg_data);
    end
    send(LDI, 2, 0, 8'hC8);
    send(LDI, 3, 0, 8'h64);
    send(ADD, 2, 3, 0);
    n_checks++;
    if ({result, flag_carry, flag_overflow} !== {8'h2C, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_carry: got res=%h c=%b v=%b, expected res=2c c=1 v=0",
               result, flag_carry, flag_overflow);
    end
    send(LDI, 4, 0, 8'h80);
    send(LDI, 5, 0, 8'h01);
    send(SUB, 4, 5, 0);
    n_checks++;
    if ({result, flag_carry, flag_overflow} !== {8'h7F, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_overflow: got res=%h c=%b v=%b, expected res=7f c=0 v=1",
               result, flag_carry, flag_overflow);
    end
  endtask

  task automatic test_mul;
    int lat, low;
    send(LDI, 0, 0, 8'h10);
    send(LDI, 1, 0, 8'h20);
    send(MUL, 0, 1, 0);
    wait_result(lat, low);
    n_checks++;
    if (lat !== 8 || low !== 7) begin
      n_fail++;
      $display("FAIL mul_latency: got latency=%0d ready_low=%0d, expected latency=8 ready_low=7",
               lat, low);
    end
    n_checks++;
    if ({instr_ready, result, flag_zero, flag_overflow} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mul_result: got rdy=%b res=%h z=%b v=%b, expected rdy=1 res=00 z=1 v=1",
               instr_ready, result, flag_zero, flag_overflow);
    end
    @(negedge clk);
    send(LDI, 0, 0, 8'h10);
    send(MULH, 0, 1, 0);
    wait_result(lat, low);
    n_checks++;
    if (lat !== 8 || result !== 8'h02) begin
      n_fail++;
      $display("FAIL mulh_result: got latency=%0d res=%h, expected latency=8 res=02", lat, result);
    end
    @(negedge clk);
  endtask

  task automatic test_div;
    int lat, low;
    send(LDI, 2, 0, 8'd200);
    send(LDI, 3, 0, 8'd7);
    send(DIV, 2, 3, 0);
    wait_result(lat, low);
    n_checks++;
    if (lat !== 8 || result !== 8'h1C) begin
      n_fail++;
      $display("FAIL div_result: got latency=%0d res=%h, expected latency=8 res=1c", lat, result);
    end
    @(negedge clk);
    send(LDI, 2, 0, 8'd200);
    send(MOD, 2, 3, 0);
    wait_result(lat, low);
    n_checks++;
    if (result !== 8'h04) begin
      n_fail++;
      $display("FAIL mod_result: got res=%h, expected res=04", result);
    end
    @(negedge clk);
    send(LDI, 6, 0, 8'd0);
    send(LDI, 2, 0, 8'd200);
    send(DIV, 2, 6, 0);
    wait_result(lat, low);
    n_checks++;
    if (lat !== 8 || result !== 8'hFF || flag_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL div_by_zero: got latency=%0d res=%h v=%b, expected latency=8 res=ff v=1",
               lat, result, flag_overflow);
    end
    @(negedge clk);
    send(LDI, 2, 0, 8'd200);
    send(MOD, 2, 6, 0);
    wait_result(lat, low);
    n_checks++;
    if (result !== 8'hC8 || flag_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mod_by_zero: got res=%h v=%b, expected res=c8 v=1", result, flag_overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    send(LDI, 4, 0, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (instr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got instr_ready=%b, expected 1", k, instr_ready);
      end
      send(SHL, 4, 4, 0);
      n_checks++;
      if (result_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_valid%0d: got result_valid=%b, expected 1", k, result_valid);
      end
      if (k == 7) begin
        n_checks++;
        if ({result, flag_sign} !== {8'h80, 1'b1}) begin
          n_fail++;
          $display("FAIL shl_msb: got res=%h s=%b, expected res=80 s=1", result, flag_sign);
        end
      end
      if (k == 8) begin
        n_checks++;
        if ({result, flag_carry, flag_zero} !== {8'h00, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL shl_out: got res=%h c=%b z=%b, expected res=00 c=1 z=1",
                   result, flag_carry, flag_zero);
        end
      end
    end
  endtask

  task automatic test_nop;
    send(NOP, 0, 1, 8'hAA);
    n_checks++;
    if ({result_valid, result, flag_zero, flag_carry, flag_sign, flag_parity, flag_overflow} !==
        {1'b0, 8'h00, 5'b11010}) begin
      n_fail++;
      $display("FAIL nop_hold: got rv=%b res=%h zcspv=%b%b%b%b%b, expected rv=0 res=00 zcspv=11010",
               result_valid, result, flag_zero, flag_carry, flag_sign, flag_parity, flag_overflow);
    end
    dbg_addr = 0;
    #1;
    n_checks++;
    if (dbg_data !== mdl[0]) begin
      n_fail++;
      $display("FAIL nop_no_write: got r0=%h, expected %h", dbg_data, mdl[0]);
    end
  endtask

  task automatic test_random;
    int guard;
    for (int n = 0; n < 40; n++) begin
      send(5'($urandom_range(0, 31)), AW'($urandom_range(0, NR - 1)),
           AW'($urandom_range(0, NR - 1)), W'($urandom_range(0, 255)));
    end
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d results outstanding, expected 0", q.size());
    end
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if (dbg_data !== mdl[i]) begin
        n_fail++;
        $display("FAIL random_reg%0d: got %h, expected %h", i, dbg_data, mdl[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int rv_seen;
    send(LDI, 2, 0, 8'd200);
    send(LDI, 3, 0, 8'd7);
    send(DIV, 2, 3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    n_checks++;
    if ({instr_ready, result_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy=%b rv=%b, expected rdy=1 rv=0", instr_ready, result_valid);
    end
    for (int i = 0; i < NR; i++) begin
      mdl[i]   = '0;
      dbg_addr = AW'(i);
      #1;
      n_checks++;
      if (dbg_data !== 8'h00) begin
        n_fail++;
        $display("FAIL midop_reg%0d: got %h, expected 00", i, dbg_data);
      end
    end
    @(negedge clk);
    rst_n   = 1'b1;
    rv_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++;
      $display("FAIL midop_discard: got %0d result_valid cycles, expected 0", rv_seen);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_nop();
    test_random();
    test_reset_midop();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
